// File: rtl/rs_dispatch_ctrl_if.sv
// Dispatch-side bundle between rename/decode, the RS array and rs_dispatch_ctrl.
// Latency: none; this file only groups signals.
// Backpressure: dispatch_stall tells the front end to hold the op it is presenting.
interface rs_dispatch_ctrl_if #(parameter int CW = 7);
   logic              dispatch_valid;
   logic [2:0]        dispatch_type;
   logic [4:0]        rs_issue;
   logic              Predict_Result;
   logic              exception_sig;
   logic              mret_sig;
   logic [4:0]        RS_start;
   logic              dispatch_stall;
   logic [5*CW-1:0]   credits;
   logic [31:0]       stall_count;
   logic [1:0]        err;

   // Front end / RS side: drives ops, issue pulses and flush sources.
   modport master (
      output dispatch_valid, dispatch_type, rs_issue, Predict_Result, exception_sig, mret_sig,
      input  RS_start, dispatch_stall, credits, stall_count, err
   );

   // Scheduler side.
   modport slave (
      input  dispatch_valid, dispatch_type, rs_issue, Predict_Result, exception_sig, mret_sig,
      output RS_start, dispatch_stall, credits, stall_count, err
   );
endinterface

// File: rtl/rs_dispatch_ctrl.sv
// Credit-based dispatch steering into five reservation stations (ALU, BR, MUL, DIV, MEM).
// Latency: zero; RS_start/dispatch_stall are combinational from registered credits and state.
// Backpressure: stalls when the target RS has no credit, on a flush, and while a flush drains.
module rs_dispatch_ctrl #(
   parameter int RS_DEPTH   = 64,
   parameter int CW         = $clog2(RS_DEPTH + 1),
   parameter int FLUSH_WAIT = 2
) (
   input  logic               clk,
   input  logic               reset,
   rs_dispatch_ctrl_if.slave  bus
);
   localparam int           FW   = (FLUSH_WAIT > 1) ? $clog2(FLUSH_WAIT) : 1;
   localparam logic [CW-1:0] FULL = CW'(RS_DEPTH);

   typedef enum logic {ST_RUN, ST_FLUSH} state_t;

   state_t          state_q;
   logic [FW-1:0]   fcnt_q;
   logic [CW-1:0]   cred_q [5];
   logic [31:0]     stall_cnt_q;
   logic [1:0]      err_q;

   logic            flush;
   logic            legal;
   logic            sel_zero;
   logic [4:0]      start_c;
   logic            stall_c;

   assign flush = bus.Predict_Result | bus.exception_sig | bus.mret_sig;
   assign legal = (bus.dispatch_type < 3'd5);

   // Look up whether the targeted RS is out of credit (illegal codes never match).
   always_comb begin
      sel_zero = 1'b0;
      case (bus.dispatch_type)
         3'd0:    sel_zero = (cred_q[0] == '0);
         3'd1:    sel_zero = (cred_q[1] == '0);
         3'd2:    sel_zero = (cred_q[2] == '0);
         3'd3:    sel_zero = (cred_q[3] == '0);
         3'd4:    sel_zero = (cred_q[4] == '0);
         default: sel_zero = 1'b0;
      endcase
   end

   // Accept/stall decision; everything is held quiet while reset is asserted.
   always_comb begin
      start_c = '0;
      stall_c = 1'b0;
      if (!reset) begin
         if (state_q == ST_FLUSH) begin
            stall_c = bus.dispatch_valid;
         end else if (bus.dispatch_valid && legal) begin
            if (sel_zero || flush)
               stall_c = 1'b1;
            else
               start_c = 5'b00001 << bus.dispatch_type;
         end
      end
   end

   // Flush FSM, credit bookkeeping, stall counter and sticky error flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_RUN;
         fcnt_q      <= '0;
         stall_cnt_q <= '0;
         err_q       <= '0;
         for (int i = 0; i < 5; i++) cred_q[i] <= FULL;
      end else begin
         if (stall_c)
            stall_cnt_q <= stall_cnt_q + 32'd1;
         if (bus.dispatch_valid && !legal)
            err_q[1] <= 1'b1;
         if (flush) begin
            // Every RS is emptied by the flush, so all credits come back at once.
            state_q <= ST_FLUSH;
            fcnt_q  <= FW'(FLUSH_WAIT - 1);
            for (int i = 0; i < 5; i++) cred_q[i] <= FULL;
         end else if (state_q == ST_FLUSH) begin
            if (fcnt_q == '0)
               state_q <= ST_RUN;
            else
               fcnt_q <= fcnt_q - FW'(1);
         end else begin
            for (int i = 0; i < 5; i++) begin
               if (bus.rs_issue[i] && !start_c[i]) begin
                  // An issue with a full RS means the RS and this counter disagree.
                  if (cred_q[i] == FULL)
                     err_q[0] <= 1'b1;
                  else
                     cred_q[i] <= cred_q[i] + CW'(1);
               end else if (start_c[i] && !bus.rs_issue[i]) begin
                  cred_q[i] <= cred_q[i] - CW'(1);
               end
            end
         end
      end
   end

   generate
      for (genvar g = 0; g < 5; g++) begin : g_cred
         assign bus.credits[g*CW +: CW] = cred_q[g];
      end
   endgenerate

   assign bus.RS_start       = start_c;
   assign bus.dispatch_stall = stall_c;
   assign bus.stall_count    = stall_cnt_q;
   assign bus.err            = err_q;
endmodule

// File: tb/tb_rs_dispatch_ctrl.sv
// Self-checking bench for rs_dispatch_ctrl: scoreboard of expected start/stall per cycle.
// Latency: strobes checked 1ns after inputs change; registered state 1ns after posedge.
// Backpressure: stall expectations come from a bench-side credit model.
module tb_rs_dispatch_ctrl;
   logic clk;
   logic reset;

   rs_dispatch_ctrl_if #(.CW(7)) bus ();

   rs_dispatch_ctrl #(.RS_DEPTH(64), .CW(7), .FLUSH_WAIT(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total;
   int bad;
   logic [5:0] exp_q [$];
   logic [5:0] got;
   logic [5:0] exp;
   int         mcred [5];
   int         mstall;

   function automatic logic [6:0] cr(input int idx);
      return bus.credits[idx*7 +: 7];
   endfunction

   // fl = {mret, exception, mispredict}
   task automatic drive(input logic v, input logic [2:0] t, input logic [4:0] iss, input logic [2:0] fl);
      bus.dispatch_valid = v;
      bus.dispatch_type  = t;
      bus.rs_issue       = iss;
      bus.Predict_Result = fl[0];
      bus.exception_sig  = fl[1];
      bus.mret_sig       = fl[2];
   endtask

   task automatic test_reset;
      reset = 1'b1;
      drive(1'b1, 3'd0, 5'b0, 3'b0);
      exp_q.push_back({5'b00000, 1'b0});
      #1;
      got = {bus.RS_start, bus.dispatch_stall};
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL reset_strobes got=%b want=%b", got, exp); end
      @(posedge clk); #1;
      @(negedge clk);
      reset = 1'b0;
      drive(1'b0, 3'd0, 5'b0, 3'b0);
      for (int i = 0; i < 5; i++) mcred[i] = 64;
      mstall = 0;
      exp_q.push_back({5'b00000, 1'b0});
      #1;
      got = {bus.RS_start, bus.dispatch_stall};
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL idle_strobes got=%b want=%b", got, exp); end
      total++;
      if (bus.credits !== {5{7'd64}}) begin bad++; $display("FAIL reset_credits got=%h want=%h", bus.credits, {5{7'd64}}); end
      total++;
      if (bus.err !== 2'b00) begin bad++; $display("FAIL reset_err got=%b want=00", bus.err); end
      total++;
      if (bus.stall_count !== 32'd0) begin bad++; $display("FAIL reset_stall_count got=%0d want=0", bus.stall_count); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      for (int n = 0; n < 65; n++) begin
         @(negedge clk);
         drive(1'b1, 3'd1, 5'b0, 3'b0);
         if (mcred[1] != 0) begin
            exp_q.push_back({5'b00010, 1'b0});
            mcred[1]--;
         end else begin
            exp_q.push_back({5'b00000, 1'b1});
            mstall++;
         end
         #1;
         got = {bus.RS_start, bus.dispatch_stall};
         exp = exp_q.pop_front();
         total++;
         if (got !== exp) begin bad++; $display("FAIL b2b_dispatch[%0d] got=%b want=%b", n, got, exp); end
         if (n == 63) begin
            @(posedge clk); #1;
            total++;
            if (cr(1) !== 7'(mcred[1])) begin bad++; $display("FAIL b2b_br_credit got=%0d want=%0d", cr(1), mcred[1]); end
         end else begin
            @(posedge clk); #1;
         end
      end
      total++;
      if (bus.stall_count !== 32'(mstall)) begin bad++; $display("FAIL b2b_stall_count got=%0d want=%0d", bus.stall_count, mstall); end
   endtask

   task automatic test_issue_same_cycle;
      @(negedge clk);
      drive(1'b1, 3'd1, 5'b00010, 3'b0);
      exp_q.push_back({5'b00000, 1'b1});
      mstall++;
      mcred[1]++;
      #1;
      got = {bus.RS_start, bus.dispatch_stall};
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL issue_same_cycle got=%b want=%b", got, exp); end
      @(posedge clk); #1;
      total++;
      if (cr(1) !== 7'(mcred[1])) begin bad++; $display("FAIL issue_credit_back got=%0d want=%0d", cr(1), mcred[1]); end
      @(negedge clk);
      drive(1'b1, 3'd1, 5'b0, 3'b0);
      exp_q.push_back({5'b00010, 1'b0});
      mcred[1]--;
      #1;
      got = {bus.RS_start, bus.dispatch_stall};
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL issue_then_accept got=%b want=%b", got, exp); end
      @(posedge clk); #1;
      total++;
      if (cr(1) !== 7'(mcred[1])) begin bad++; $display("FAIL issue_credit_zero got=%0d want=%0d", cr(1), mcred[1]); end
   endtask

   task automatic test_flush;
      for (int n = 0; n < 54; n++) begin
         @(negedge clk);
         drive(1'b1, 3'd0, 5'b0, 3'b0);
         exp_q.push_back({5'b00001, 1'b0});
         mcred[0]--;
         #1;
         got = {bus.RS_start, bus.dispatch_stall};
         exp = exp_q.pop_front();
         total++;
         if (got !== exp) begin bad++; $display("FAIL alu_fill[%0d] got=%b want=%b", n, got, exp); end
         @(posedge clk); #1;
      end
      total++;
      if (cr(0) !== 7'd10) begin bad++; $display("FAIL alu_credit_10 got=%0d want=10", cr(0)); end
      @(negedge clk);
      drive(1'b0, 3'd0, 5'b0, 3'b001);
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) mcred[i] = 64;
      total++;
      if (bus.credits !== {5{7'd64}}) begin bad++; $display("FAIL flush_credits got=%h want=%h", bus.credits, {5{7'd64}}); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         drive(1'b1, 3'd0, 5'b0, 3'b0);
         if (c < 2) begin
            exp_q.push_back({5'b00000, 1'b1});
            mstall++;
         end else begin
            exp_q.push_back({5'b00001, 1'b0});
            mcred[0]--;
         end
         #1;
         got = {bus.RS_start, bus.dispatch_stall};
         exp = exp_q.pop_front();
         total++;
         if (got !== exp) begin bad++; $display("FAIL flush_hold[%0d] got=%b want=%b", c, got, exp); end
         @(posedge clk); #1;
      end
      total++;
      if (cr(0) !== 7'(mcred[0])) begin bad++; $display("FAIL flush_alu_after got=%0d want=%0d", cr(0), mcred[0]); end
      total++;
      if (bus.stall_count !== 32'(mstall)) begin bad++; $display("FAIL flush_stall_count got=%0d want=%0d", bus.stall_count, mstall); end
   endtask

   task automatic test_errors;
      @(negedge clk);
      drive(1'b0, 3'd0, 5'b00100, 3'b0);
      @(posedge clk); #1;
      total++;
      if (cr(2) !== 7'd64) begin bad++; $display("FAIL overflow_credit got=%0d want=64", cr(2)); end
      total++;
      if (bus.err !== 2'b01) begin bad++; $display("FAIL overflow_err got=%b want=01", bus.err); end
      @(negedge clk);
      drive(1'b1, 3'd6, 5'b0, 3'b0);
      exp_q.push_back({5'b00000, 1'b0});
      #1;
      got = {bus.RS_start, bus.dispatch_stall};
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL illegal_type_strobes got=%b want=%b", got, exp); end
      @(posedge clk); #1;
      total++;
      if (bus.err !== 2'b11) begin bad++; $display("FAIL illegal_type_err got=%b want=11", bus.err); end
      total++;
      if (bus.credits !== {7'(mcred[4]), 7'(mcred[3]), 7'(mcred[2]), 7'(mcred[1]), 7'(mcred[0])}) begin
         bad++; $display("FAIL illegal_type_credits got=%h", bus.credits);
      end
   endtask

   task automatic test_flush_reload;
      @(negedge clk);
      drive(1'b0, 3'd0, 5'b0, 3'b010);
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) mcred[i] = 64;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         drive(1'b1, 3'd4, 5'b0, (c == 0) ? 3'b100 : 3'b000);
         if (c < 3) begin
            exp_q.push_back({5'b00000, 1'b1});
            mstall++;
         end else begin
            exp_q.push_back({5'b10000, 1'b0});
            mcred[4]--;
         end
         #1;
         got = {bus.RS_start, bus.dispatch_stall};
         exp = exp_q.pop_front();
         total++;
         if (got !== exp) begin bad++; $display("FAIL reload_hold[%0d] got=%b want=%b", c, got, exp); end
         @(posedge clk); #1;
      end
      total++;
      if (cr(4) !== 7'(mcred[4])) begin bad++; $display("FAIL reload_mem_credit got=%0d want=%0d", cr(4), mcred[4]); end
      total++;
      if (bus.stall_count !== 32'(mstall)) begin bad++; $display("FAIL reload_stall_count got=%0d want=%0d", bus.stall_count, mstall); end
      total++;
      if (bus.err !== 2'b11) begin bad++; $display("FAIL err_sticky got=%b want=11", bus.err); end
   endtask

   task automatic test_reset_mid_flush;
      @(negedge clk);
      drive(1'b0, 3'd0, 5'b0, 3'b001);
      @(posedge clk); #1;
      @(negedge clk);
      reset = 1'b1;
      drive(1'b1, 3'd0, 5'b0, 3'b0);
      exp_q.push_back({5'b00000, 1'b0});
      #1;
      got = {bus.RS_start, bus.dispatch_stall};
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL midflush_reset_strobes got=%b want=%b", got, exp); end
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) mcred[i] = 64;
      mstall = 0;
      @(negedge clk);
      reset = 1'b0;
      exp_q.push_back({5'b00001, 1'b0});
      mcred[0]--;
      #1;
      got = {bus.RS_start, bus.dispatch_stall};
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL midflush_accept got=%b want=%b", got, exp); end
      @(posedge clk); #1;
      total++;
      if (cr(0) !== 7'(mcred[0])) begin bad++; $display("FAIL midflush_credit got=%0d want=%0d", cr(0), mcred[0]); end
      total++;
      if (bus.err !== 2'b00) begin bad++; $display("FAIL midflush_err got=%b want=00", bus.err); end
      total++;
      if (bus.stall_count !== 32'(mstall)) begin bad++; $display("FAIL midflush_stall_count got=%0d want=%0d", bus.stall_count, mstall); end
      @(negedge clk);
      drive(1'b0, 3'd0, 5'b0, 3'b0);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_back_to_back();
      test_issue_same_cycle();
      test_flush();
      test_errors();
      test_flush_reload();
      test_reset_mid_flush();
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
